// File: rtl/branch_pred_pkg.sv
// Shared constants for the branch-history counter bank.
// Counter encodings, reset default and lookup address width.
package branch_pred_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_state_e;

  localparam logic [1:0] CTR_INIT_DEF = 2'b01;
  localparam int         ADDR_W_DEF   = 3;

endpackage

// File: rtl/sat_counter_2bit.sv
// One 2-bit saturating direction counter.
// MISPRED flags an enabled update whose outcome disagrees with the current MSB.
module sat_counter_2bit
  import branch_pred_pkg::*;
#(
  parameter logic [1:0] INIT = CTR_INIT_DEF
) (
  input  logic       CLOCK,
  input  logic       RESETN,
  input  logic       EN,
  input  logic       OUTCOME,
  output logic [1:0] STATE,
  output logic       MISPRED
);

  ctr_state_e r_state;
  ctr_state_e w_next;

  // state register, reset to the weak initial state
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) r_state <= ctr_state_e'(INIT);
    else         r_state <= w_next;
  end

  // step toward the resolved outcome, saturating at both ends
  always_comb begin
    w_next = r_state;
    if (EN) begin
      unique case (r_state)
        SNT: w_next = OUTCOME ? WNT : SNT;
        WNT: w_next = OUTCOME ? WT  : SNT;
        WT:  w_next = OUTCOME ? ST  : WNT;
        ST:  w_next = OUTCOME ? ST  : WT;
        default: w_next = r_state;
      endcase
    end
  end

  assign STATE   = r_state;
  assign MISPRED = EN & (OUTCOME != r_state[1]);

endmodule

// File: rtl/two_bit_counter_bank.sv
// Bank of saturating branch counters with registered lookup.
// Also tracks saturating update and misprediction counts.
module two_bit_counter_bank
  import branch_pred_pkg::*;
#(
  parameter int         NUM_ENTRIES = 2,
  parameter int         ADDR_W      = ADDR_W_DEF,
  parameter logic [1:0] CTR_INIT    = CTR_INIT_DEF,
  parameter int         STAT_W      = 16
) (
  input  logic                   CLOCK,
  input  logic                   RESETN,
  input  logic [NUM_ENTRIES-1:0] UPD_EN,
  input  logic [NUM_ENTRIES-1:0] UPD_OUTCOME,
  input  logic                   LOOKUP_VALID,
  input  logic [ADDR_W-1:0]      LOOKUP_ADDR,
  output logic                   PREDICT,
  output logic                   PREDICT_VALID,
  output logic [STAT_W-1:0]      MISPRED_CNT,
  output logic [STAT_W-1:0]      UPDATE_CNT
);

  localparam logic [STAT_W:0] SAT_MAX =
    {1'b0, {STAT_W{1'b1}}};

  logic [1:0]             w_state [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] w_mis;
  logic                   w_hit;
  logic                   w_msb;
  logic [STAT_W:0]        w_upd_inc;
  logic [STAT_W:0]        w_mis_inc;
  logic [STAT_W:0]        w_upd_sum;
  logic [STAT_W:0]        w_mis_sum;

  logic                   r_predict;
  logic                   r_pvalid;
  logic [STAT_W-1:0]      r_mis_cnt;
  logic [STAT_W-1:0]      r_upd_cnt;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ctr
    sat_counter_2bit #(
      .INIT    (CTR_INIT)
    ) u_ctr (
      .CLOCK   (CLOCK),
      .RESETN  (RESETN),
      .EN      (UPD_EN[g]),
      .OUTCOME (UPD_OUTCOME[g]),
      .STATE   (w_state[g]),
      .MISPRED (w_mis[g])
    );
  end

  // address i+1 selects entry i; anything else misses
  always_comb begin
    w_hit = 1'b0;
    w_msb = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (LOOKUP_ADDR == ADDR_W'(i + 1)) begin
        w_hit = 1'b1;
        w_msb = w_state[i][1];
      end
    end
  end

  // popcounts of applied updates and mispredictions
  always_comb begin
    w_upd_inc = '0;
    w_mis_inc = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_upd_inc = w_upd_inc + (STAT_W+1)'(UPD_EN[i]);
      w_mis_inc = w_mis_inc + (STAT_W+1)'(w_mis[i]);
    end
    w_upd_sum = {1'b0, r_upd_cnt} + w_upd_inc;
    w_mis_sum = {1'b0, r_mis_cnt} + w_mis_inc;
  end

  // registered prediction, pre-update counter value
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      r_predict <= 1'b0;
      r_pvalid  <= 1'b0;
    end else begin
      r_pvalid  <= LOOKUP_VALID & w_hit;
      r_predict <= LOOKUP_VALID & w_hit & w_msb;
    end
  end

  // saturating statistics accumulators
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      r_upd_cnt <= '0;
      r_mis_cnt <= '0;
    end else begin
      r_upd_cnt <= (w_upd_sum > SAT_MAX) ?
        SAT_MAX[STAT_W-1:0] : w_upd_sum[STAT_W-1:0];
      r_mis_cnt <= (w_mis_sum > SAT_MAX) ?
        SAT_MAX[STAT_W-1:0] : w_mis_sum[STAT_W-1:0];
    end
  end

  assign PREDICT       = r_predict;
  assign PREDICT_VALID = r_pvalid;
  assign MISPRED_CNT   = r_mis_cnt;
  assign UPDATE_CNT    = r_upd_cnt;

endmodule

// File: tb/tb_two_bit_counter_bank.sv
// Directed bench for two_bit_counter_bank.
// Hand-computed expectations for training, lookup and stats.
module tb_two_bit_counter_bank;

  logic        clk;
  logic        rst_n;
  logic [1:0]  upd_en;
  logic [1:0]  upd_out;
  logic        lk_v;
  logic [2:0]  lk_a;
  logic        pred;
  logic        pvld;
  logic [15:0] mis_cnt;
  logic [15:0] upd_cnt;

  int checks;
  int errors;

  two_bit_counter_bank #(
    .NUM_ENTRIES (2),
    .ADDR_W      (3),
    .CTR_INIT    (2'b01),
    .STAT_W      (16)
  ) dut (
    .CLOCK         (clk),
    .RESETN        (rst_n),
    .UPD_EN        (upd_en),
    .UPD_OUTCOME   (upd_out),
    .LOOKUP_VALID  (lk_v),
    .LOOKUP_ADDR   (lk_a),
    .PREDICT       (pred),
    .PREDICT_VALID (pvld),
    .MISPRED_CNT   (mis_cnt),
    .UPDATE_CNT    (upd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
        tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    upd_en  = 2'b00;
    upd_out = 2'b00;
    lk_v    = 1'b0;
    lk_a    = 3'd0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic look(input logic [2:0] a);
    lk_v = 1'b1;
    lk_a = a;
    step();
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst_pred", pred, 0);
    chk("rst_pvld", pvld, 0);
    chk("rst_mis", mis_cnt, 0);
    chk("rst_upd", upd_cnt, 0);
    step();
    rst_n = 1'b1;
    step();

    // 1: reset lookup of e0 (WNT)
    look(3'b001);
    chk("t1_pred", pred, 0);
    chk("t1_pvld", pvld, 1);
    chk("t1_mis", mis_cnt, 0);
    chk("t1_upd", upd_cnt, 0);
    step();
    chk("t1_noreq_pvld", pvld, 0);

    // 2: three taken on e0, 01->10->11->11
    for (int i = 0; i < 3; i++) begin
      upd_en  = 2'b01;
      upd_out = 2'b01;
      step();
    end
    idle();
    look(3'b001);
    chk("t2_pred", pred, 1);
    chk("t2_upd", upd_cnt, 3);
    chk("t2_mis", mis_cnt, 1);

    // hold: outcome ignored without enable
    upd_en  = 2'b00;
    upd_out = 2'b11;
    step();
    chk("hold_upd", upd_cnt, 3);

    // 3: two not-taken, 11->10->01, both mispredict
    for (int i = 0; i < 2; i++) begin
      upd_en  = 2'b01;
      upd_out = 2'b00;
      step();
    end
    idle();
    look(3'b001);
    chk("t3_pred", pred, 0);
    chk("t3_upd", upd_cnt, 5);
    chk("t3_mis", mis_cnt, 3);

    // 4: dual update from reset
    do_reset();
    upd_en  = 2'b11;
    upd_out = 2'b10;
    step();
    idle();
    chk("t4_upd", upd_cnt, 2);
    chk("t4_mis", mis_cnt, 1);
    look(3'b010);
    chk("t4_e1", pred, 1);
    look(3'b001);
    chk("t4_e0", pred, 0);
    // e0 at SNT: not-taken saturates, no mispredict
    upd_en  = 2'b01;
    upd_out = 2'b00;
    step();
    idle();
    chk("t4_sat_mis", mis_cnt, 1);
    look(3'b001);
    chk("t4_sat_e0", pred, 0);
    // e0 SNT -> WNT, still predicts not-taken
    upd_en  = 2'b01;
    upd_out = 2'b01;
    step();
    idle();
    look(3'b001);
    chk("t4_snt_up", pred, 0);

    // idle demux pattern trains e1 down
    do_reset();
    upd_en  = 2'b10;
    upd_out = 2'b00;
    step();
    idle();
    chk("idle_upd", upd_cnt, 1);
    chk("idle_mis", mis_cnt, 0);
    upd_en  = 2'b10;
    upd_out = 2'b10;
    step();
    idle();
    look(3'b010);
    chk("idle_e1", pred, 0);

    // 5: same-cycle lookup and update, no bypass
    do_reset();
    lk_v    = 1'b1;
    lk_a    = 3'b010;
    upd_en  = 2'b10;
    upd_out = 2'b10;
    step();
    idle();
    chk("t5_pred", pred, 0);
    chk("t5_pvld", pvld, 1);
    look(3'b010);
    chk("t5_rep", pred, 1);

    // 6: out-of-range addresses
    look(3'b011);
    chk("t6_a3_pvld", pvld, 0);
    chk("t6_a3_pred", pred, 0);
    look(3'b000);
    chk("t6_a0_pvld", pvld, 0);
    look(3'b111);
    chk("t6_a7_pvld", pvld, 0);

    // saturation: alternating outcomes mispredict every update
    do_reset();
    for (int i = 0; i < 32767; i++) begin
      upd_en  = 2'b11;
      upd_out = (i % 2 == 0) ? 2'b11 : 2'b00;
      step();
    end
    idle();
    chk("sat_mis_pre", mis_cnt, 16'hFFFE);
    chk("sat_upd_pre", upd_cnt, 16'hFFFE);
    upd_en  = 2'b01;
    upd_out = 2'b00;
    step();
    chk("sat_mis_max", mis_cnt, 16'hFFFF);
    chk("sat_upd_max", upd_cnt, 16'hFFFF);
    upd_en  = 2'b11;
    upd_out = 2'b01;
    step();
    idle();
    chk("sat_mis_hold", mis_cnt, 16'hFFFF);
    chk("sat_upd_hold", upd_cnt, 16'hFFFF);

    // mid-burst async reset
    lk_v    = 1'b1;
    lk_a    = 3'b001;
    upd_en  = 2'b11;
    upd_out = 2'b11;
    step();
    chk("mb_pvld_pre", pvld, 1);
    rst_n = 1'b0;
    #1;
    chk("mb_pred", pred, 0);
    chk("mb_pvld", pvld, 0);
    chk("mb_mis", mis_cnt, 0);
    chk("mb_upd", upd_cnt, 0);
    idle();
    step();
    rst_n = 1'b1;
    step();
    look(3'b001);
    chk("mb_e0_init", pred, 0);
    chk("mb_e0_vld", pvld, 1);
    look(3'b010);
    chk("mb_e1_init", pred, 0);
    chk("mb_stats", upd_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
